// File: rtl/pkt_mem_responder_pkg.sv
// Shared types and constants for the packet/instruction memory responder.
// Bus widths, lane geometry and the registered read-select record.
package pkt_mem_responder_pkg;

    localparam int ADDR_BUS      = 32;
    localparam int DATA_BUS      = 32;
    localparam int MEM_BYTES_DEF = 1024;
    localparam int WIDTH_MAX     = 4;
    localparam int LANES         = 4;
    localparam int LANE_W        = 2;
    localparam int BYTE_W        = 8;

    localparam logic [DATA_BUS-1:0] ZERO_WORD = '0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef struct packed {
        logic              valid;
        logic [LANE_W-1:0] lane;
        logic [2:0]        width;
        logic              err;
    } rd_sel_t;

    // Oversized widths execute as a full word.
    function automatic logic [2:0] clamp_width(input logic [3:0] w);
        if (w > 4'(WIDTH_MAX)) begin
            return 3'(WIDTH_MAX);
        end
        return w[2:0];
    endfunction

endpackage

// File: rtl/pkt_mem_responder_mem_byte_bank.sv
// One byte lane of the responder RAM: single address, one write port,
// registered read data that holds when no read is requested.
module mem_byte_bank
    import pkt_mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    output logic [BYTE_W-1:0] rdata_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] rdata_d;
    logic [BYTE_W-1:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_mem_responder.sv
// Big-endian byte-addressed memory answering executor requests, with a
// low-priority byte load port for the ingress path.
module pkt_mem_responder
    import pkt_mem_responder_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = ADDR_BUS,
    parameter int DATA_W    = DATA_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [3:0]        mem_width_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              err_o,
    input  logic              load_valid_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [7:0]        load_byte_i,
    output logic              load_ready_o
);

    localparam int EA_W = $clog2(MEM_BYTES);
    localparam int RW   = EA_W - LANE_W;
    localparam int ROWS = MEM_BYTES / LANES;

    logic [EA_W-1:0]   ea;
    logic [EA_W-1:0]   ld_ea;
    logic [LANE_W-1:0] a_lo;
    logic [RW-1:0]     row0;
    logic [RW-1:0]     ld_row;
    logic [2:0]        w_eff;
    logic              w_bad;
    logic              req_wr;
    logic              req_rd;
    logic              unused_addr;

    rd_sel_t rd_sel_d;
    rd_sel_t rd_sel_q;

    logic [BYTE_W-1:0] bank_rdata [LANES];
    logic [DATA_W-1:0] rd_word;
    logic [LANE_W-1:0] lane_sel;

    assign ea     = mem_addr_i[EA_W-1:0];
    assign ld_ea  = load_addr_i[EA_W-1:0];
    assign a_lo   = ea[LANE_W-1:0];
    assign row0   = ea[EA_W-1:LANE_W];
    assign ld_row = ld_ea[EA_W-1:LANE_W];
    assign w_eff  = clamp_width(mem_width_i);
    assign w_bad  = (mem_width_i == 4'd0) || (mem_width_i > 4'(WIDTH_MAX));
    assign req_wr = mem_ce_i & mem_we_i & ~rst;
    assign req_rd = mem_ce_i & ~mem_we_i & ~rst;

    assign load_ready_o = load_valid_i & ~mem_ce_i;

    assign unused_addr = ^{mem_addr_i[ADDR_W-1:EA_W], load_addr_i[ADDR_W-1:EA_W]};

    for (genvar b = 0; b < LANES; b++) begin : g_lane
        logic [LANE_W-1:0] k;
        logic [LANE_W-1:0] sh;
        logic              hit;
        logic              ld_hit;
        logic              we;
        logic              re;
        logic [RW-1:0]     row;
        logic [BYTE_W-1:0] wbyte;

        // k is this lane's position within the access, counted from byte A.
        assign k      = LANE_W'(b) - a_lo;
        assign hit    = (w_eff != 3'd0) && ({1'b0, k} < w_eff);
        assign sh     = LANE_W'(w_eff - 3'd1) - k;
        assign ld_hit = load_ready_o && (ld_ea[LANE_W-1:0] == LANE_W'(b));
        assign we     = ld_hit | (req_wr & hit);
        assign re     = req_rd & hit;
        assign row    = ld_hit ? ld_row
                      : row0 + ((LANE_W'(b) < a_lo) ? RW'(1) : RW'(0));
        assign wbyte  = ld_hit ? load_byte_i : mem_data_i[{sh, 3'b000} +: 8];

        mem_byte_bank #(
            .DEPTH (ROWS)
        ) u_bank (
            .clk     (clk),
            .we_i    (we),
            .re_i    (re),
            .addr_i  (row),
            .wdata_i (wbyte),
            .rdata_o (bank_rdata[b])
        );
    end

    always_comb begin
        rd_sel_d     = rd_sel_q;
        rd_sel_d.err = mem_ce_i & w_bad & ~rst;
        if (req_rd) begin
            rd_sel_d.valid = (w_eff != 3'd0);
            rd_sel_d.lane  = a_lo;
            rd_sel_d.width = w_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel_q <= '0;
        end else begin
            rd_sel_q <= rd_sel_d;
        end
    end

    // Result byte p (from LSB) is access byte W-1-p, held in lane A+W-1-p.
    always_comb begin
        rd_word  = ZERO_WORD;
        lane_sel = '0;
        if (rd_sel_q.valid) begin
            for (int p = 0; p < LANES; p++) begin
                if (3'(p) < rd_sel_q.width) begin
                    lane_sel = rd_sel_q.lane
                             + LANE_W'(rd_sel_q.width - 3'(p) - 3'd1);
                    rd_word[8*p +: 8] = bank_rdata[lane_sel];
                end
            end
        end
    end

    assign mem_data_o = rd_word;
    assign err_o      = rd_sel_q.err;

endmodule

// File: tb/tb_pkt_mem_responder.sv
// Randomized bench for pkt_mem_responder against a byte-array model.
// Directed scenarios first, then random request/load traffic.
module tb_pkt_mem_responder;

    localparam int MEMB = 1024;

    logic        clk;
    logic        rst;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_width_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        err_o;
    logic        load_valid_i;
    logic [31:0] load_addr_i;
    logic [7:0]  load_byte_i;
    logic        load_ready_o;

    logic [7:0]  model_mem [MEMB];
    logic [31:0] exp_data;
    logic        exp_err;
    int          n_vec;
    int          n_err;

    pkt_mem_responder #(
        .MEM_BYTES (MEMB),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_ce_i     (mem_ce_i),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_width_i  (mem_width_i),
        .mem_data_i   (mem_data_i),
        .mem_data_o   (mem_data_o),
        .err_o        (err_o),
        .load_valid_i (load_valid_i),
        .load_addr_i  (load_addr_i),
        .load_byte_i  (load_byte_i),
        .load_ready_o (load_ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int eff_w(input logic [3:0] w);
        if (w > 4'd4) return 4;
        return int'(w);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a,
                                             input logic [3:0] w);
        logic [31:0] r;
        int ea;
        r  = 0;
        ea = int'(a % MEMB);
        for (int k = 0; k < eff_w(w); k++) begin
            r = (r << 8) | 32'(model_mem[(ea + k) % MEMB]);
        end
        return r;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [3:0] w,
                             input logic [31:0] d);
        int ea;
        int n;
        ea = int'(a % MEMB);
        n  = eff_w(w);
        for (int k = 0; k < n; k++) begin
            model_mem[(ea + k) % MEMB] = 8'(d >> (8 * (n - 1 - k)));
        end
    endtask

    task automatic tick(input logic r, input logic ce, input logic we,
                        input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, input logic lv,
                        input logic [31:0] la, input logic [7:0] lb);
        logic rdy;
        rst          = r;
        mem_ce_i     = ce;
        mem_we_i     = we;
        mem_addr_i   = a;
        mem_width_i  = w;
        mem_data_i   = d;
        load_valid_i = lv;
        load_addr_i  = la;
        load_byte_i  = lb;
        rdy          = lv && !ce;
        #1;
        chk("load_ready", 32'(load_ready_o), 32'(rdy));
        if (r) begin
            exp_data = 0;
            exp_err  = 0;
        end else begin
            exp_err = ce && (w == 0 || w > 4);
            if (ce && !we) exp_data = ref_read(a, w);
            if (ce && we) ref_write(a, w, d);
        end
        if (rdy) model_mem[int'(la % MEMB)] = lb;
        @(posedge clk);
        #1;
        chk("rd_data", mem_data_o, exp_data);
        chk("err", 32'(err_o), 32'(exp_err));
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] w);
        tick(0, 1, 0, a, w, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d);
        tick(0, 1, 1, a, w, d, 0, 0, 0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        exp_data = 0;
        exp_err  = 0;
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_data", mem_data_o, 32'h0);

        // Fill the whole RAM through the load port so the model is exact.
        for (int i = 0; i < MEMB; i++) begin
            tick(0, 0, 0, 0, 0, 0, 1, 32'(i), 8'($urandom));
        end

        wr(32'h10, 4, 32'hDEADBEEF);
        rd(32'h10, 4);
        chk("aligned_w4", mem_data_o, 32'hDEADBEEF);
        rd(32'h11, 1);
        chk("aligned_b1", mem_data_o, 32'h000000AD);

        wr(32'h23, 4, 32'h11223344);
        rd(32'h24, 2);
        chk("cross_row_w2", mem_data_o, 32'h00002233);
        rd(32'h20, 4);
        chk("cross_row_lo", {24'h0, mem_data_o[7:0]}, 32'h11);

        wr(MEMB - 2, 4, 32'hA1B2C3D4);
        rd(32'h0, 2);
        chk("wrap_w2", mem_data_o, 32'h0000C3D4);
        rd(MEMB - 2, 4);
        rd(32'hFFFF_F000 | 32'(MEMB - 1), 3);

        wr(32'h40, 2, 32'h0005);
        rd(32'h40, 2);
        wr(32'h40, 2, 32'h0008);
        rd(32'h40, 2);
        chk("rmw", mem_data_o, 32'h00000008);
        rd(32'h42, 1);

        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 32'h10, 4, 0, 1, 32'h80, 8'h5A);
        end
        tick(0, 0, 0, 0, 0, 0, 1, 32'h80, 8'h5A);
        rd(32'h80, 1);
        chk("load_byte", mem_data_o, 32'h0000005A);

        rd(32'h10, 0);
        chk("w0_data", mem_data_o, 32'h0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rd(32'h10, 7);
        chk("w7_as_w4", mem_data_o, 32'hDEADBEEF);
        wr(32'h10, 0, 32'h0);
        wr(32'h10, 15, 32'h01020304);
        rd(32'h10, 4);

        rd(32'h80, 1);
        tick(1, 1, 1, 32'h10, 4, 32'hCAFEF00D, 0, 0, 0);
        chk("rst_data", mem_data_o, 32'h0);
        rd(32'h10, 4);
        chk("rst_wr_drop", mem_data_o, 32'h01020304);

        for (int i = 0; i < 4000; i++) begin
            logic [3:0] w;
            logic [31:0] a;
            w = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(1, 4));
            a = ($urandom_range(0, 3) == 0) ? $urandom
                                            : 32'($urandom_range(0, 63));
            tick(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, a, w, $urandom,
                 $urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)),
                 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_mem_responder.md
Name: pkt_mem_responder

Overview:
- Byte-addressed packet/instruction memory that answers the executor-side memory request bus (ce/we/addr/width/data).
- Serves variable-width (1-4 byte) reads with a registered result the cycle after the request, and byte-accurate writes.
- Provides a low-priority byte load port so the ingress path can fill packet/program bytes while the executor is idle.
- Sits between the executor (and its checksum/op sub-units, via the executor's mux) and on-chip RAM.

Parameters:
- MEM_BYTES, 1024, total bytes; power of two, multiple of 4.
- ADDR_W, 32, request address width (matches ADDR_BUS).
- DATA_W, 32, data width (matches DATA_BUS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_ce_i  in  1  request valid
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  ADDR_W  byte address of the first (most significant) byte
- mem_width_i  in  4  access width in bytes
- mem_data_i  in  DATA_W  write data, right-aligned
- mem_data_o  out  DATA_W  read data, right-aligned, zero-extended
- err_o  out  1  one-cycle pulse: illegal width seen
- load_valid_i  in  1  load-port byte valid
- load_addr_i  in  ADDR_W  load byte address
- load_byte_i  in  8  load byte
- load_ready_o  out  1  load byte accepted this cycle

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Reset values: mem_data_o = 0, err_o = 0. load_ready_o is combinational. RAM contents are not cleared.
- Byte order is big-endian. An access of width W at address A covers bytes A..A+W-1; byte A maps to the most significant of the W returned bytes. Example: a 4-byte read of instruction word A returns {M[A],M[A+1],M[A+2],M[A+3]}.
- Address decode: effective byte address = addr mod MEM_BYTES. Upper bits are ignored, and an access wraps past MEM_BYTES-1 to 0.
- Storage is four byte banks, bank = ea[1:0], row = ea>>2. An unaligned access spans two rows: bank b uses row+1 when b < A[1:0]. Each bank is touched at most once per cycle.
- Read (ce=1, we=0, W in 1..4), issued at cycle N:
  - Cycle N: RAM sampled.
  - From cycle N+1: mem_data_o = selected bytes, right-aligned, upper 32-8W bits zero.
  - Latency exactly 1; back-to-back reads every cycle are supported.
- Write (ce=1, we=1, W in 1..4):
  - The low W bytes of mem_data_i are stored at the posedge of the request cycle; mem_data_i[8W-1:8W-8] goes to byte A.
  - A read in the next cycle returns the new data.
  - mem_data_o holds its previous value during writes.
- ce=0: mem_data_o holds its value; there are no RAM side effects from the request port.
- Illegal width:
  - W = 0: no RAM access; err_o pulses at N+1. On a read, mem_data_o = 0 at N+1.
  - W > 4: the access executes as W = 4; err_o pulses at N+1.
- Load port:
  - load_ready_o = load_valid_i & ~mem_ce_i.
  - When load_ready_o = 1, load_byte_i is written to bank/row of load_addr_i mod MEM_BYTES at that posedge.
  - The request port always has priority. A refused load byte must be held by the source until accepted (valid/ready).
- Simultaneous events: a request-port write and a load write in the same cycle cannot occur, because the load is refused.
- Reset mid-operation: a read pending from the cycle before reset is discarded; mem_data_o = 0 after the reset cycle. A write issued in the same cycle as rst=1 is dropped.
- Internal state:
  - Registered read-select record: valid, A[1:0], W, err.
  - Muxing stage driven from the bank outputs and that record. This is the only pipeline stage.

Decomposition:
- Shared package/def header:
  - MEM_BYTES default.
  - WIDTH_MAX = 4.
  - Byte-lane helper constants.
  - Existing ADDR_BUS, DATA_BUS, ZERO_WORD, TRUE/FALSE.
- Sub-module mem_byte_bank: single byte-wide RAM of MEM_BYTES/4 entries with one write port and one registered read port. Instantiated four times.
- Top level owns address/lane rotation, the width mask, load arbitration and error logic.

Test Plan:
- Aligned word: write addr 0x10, W=4, data 0xDEADBEEF; then read 0x10 W=4 -> mem_data_o = 0xDEADBEEF at the next cycle. Read 0x11 W=1 -> 0x000000AD.
- Unaligned/cross-row: write 0x23 W=4, data 0x11223344; then:
  - Read 0x24 W=2 -> 0x00002233.
  - Read 0x20 W=4 -> high three bytes are the prior contents, low byte 0x11.
- Wrap-around: write MEM_BYTES-2 W=4, data 0xA1B2C3D4 -> bytes land at MEM_BYTES-2, MEM_BYTES-1, 0, 1. Reading 0 W=2 returns 0x0000C3D4.
- Read-modify-write (executor add pattern): read 0x40 W=2 (value 0x0005), write 0x40 W=2 data 0x0008, read 0x40 W=2 -> 0x00000008. The byte at 0x42 is unchanged.
- Load arbitration: hold load_valid_i = 1 at addr 0x80, byte 0x5A while ce=1 for 3 cycles -> load_ready_o = 0 for those cycles. Then ce=0 -> load_ready_o = 1 and a later read of 0x80 W=1 -> 0x5A.
- Error/reset: read W=0 -> err_o = 1 for one cycle and mem_data_o = 0. Issue a read, then assert rst the next cycle -> mem_data_o = 0 and err_o = 0 after reset.
